// File: rtl/trap_commit_monitor.sv
// rtl/trap_commit_monitor.sv - retirement monitor: ebreak/timeout/abort trap report, counters, PC trace ring
module trap_commit_monitor #(
  parameter int TIMEOUT      = 1024,
  parameter int DRAIN_CYCLES = 4,
  parameter int DEPTH        = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     commit_valid,
  input  logic [63:0]              commit_pc,
  input  logic [31:0]              commit_inst,
  input  logic [63:0]              a0,
  input  logic                     abort_req,
  output logic                     stall_fetch,
  output logic                     exit,
  output logic [63:0]              exit_pc,
  output logic [31:0]              exit_inst,
  output logic [63:0]              exit_a0,
  output logic [1:0]               exit_cause,
  output logic [63:0]              cycle_cnt,
  output logic [63:0]              instret,
  input  logic [$clog2(DEPTH)-1:0] trace_rd_idx,
  output logic [63:0]              trace_rd_pc,
  output logic [$clog2(DEPTH):0]   trace_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT);
  localparam logic [31:0]   EBREAK     = 32'h0010_0073;
  localparam logic [IW-1:0] IDLE_LAST  = IW'(TIMEOUT - 2);
  localparam logic [3:0]    DRAIN_LAST = 4'(DRAIN_CYCLES - 1);
  localparam logic [AW:0]   FULL       = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {RUN, DRAIN, REPORT, HALT} state_t;

  state_t          state;
  logic [63:0]     ring [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [IW-1:0]   idle_cnt;
  logic [3:0]      drain_cnt;
  logic [63:0]     last_pc;
  logic [31:0]     last_inst;
  logic            is_ebreak;
  logic            timeout_hit;
  logic [63:0]     cur_pc;
  logic [31:0]     cur_inst;
  logic [AW-1:0]   rd_addr;

  assign is_ebreak   = commit_valid && (commit_inst == EBREAK);
  // Firing when the counter is about to step onto TIMEOUT-1 keeps it bounded there.
  assign timeout_hit = !commit_valid && (idle_cnt == IDLE_LAST);
  assign cur_pc      = commit_valid ? commit_pc : last_pc;
  assign cur_inst    = commit_valid ? commit_inst : last_inst;

  assign rd_addr     = wr_ptr - AW'(1) - trace_rd_idx;
  assign trace_rd_pc = ({1'b0, trace_rd_idx} < trace_count) ? ring[rd_addr] : 64'd0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      stall_fetch <= 1'b0;
      exit        <= 1'b0;
      exit_pc     <= '0;
      exit_inst   <= '0;
      exit_a0     <= '0;
      exit_cause  <= 2'd0;
      cycle_cnt   <= '0;
      instret     <= '0;
      trace_count <= '0;
      wr_ptr      <= '0;
      idle_cnt    <= '0;
      drain_cnt   <= '0;
      last_pc     <= '0;
      last_inst   <= '0;
      for (int i = 0; i < DEPTH; i++) ring[i] <= '0;
    end else begin
      exit <= 1'b0;
      case (state)
        RUN: begin
          cycle_cnt <= cycle_cnt + 64'd1;
          if (commit_valid) begin
            instret      <= instret + 64'd1;
            ring[wr_ptr] <= commit_pc;
            wr_ptr       <= wr_ptr + AW'(1);
            if (trace_count != FULL) trace_count <= trace_count + (AW+1)'(1);
            last_pc      <= commit_pc;
            last_inst    <= commit_inst;
            idle_cnt     <= '0;
          end else begin
            idle_cnt <= idle_cnt + IW'(1);
          end
          if (is_ebreak) begin
            exit_pc     <= commit_pc;
            exit_inst   <= commit_inst;
            exit_a0     <= a0;
            exit_cause  <= 2'd1;
            drain_cnt   <= '0;
            stall_fetch <= 1'b1;
            state       <= DRAIN;
          end else if (abort_req) begin
            exit_pc     <= cur_pc;
            exit_inst   <= cur_inst;
            exit_a0     <= 64'hFFFF_FFFF_FFFF_FFFE;
            exit_cause  <= 2'd3;
            stall_fetch <= 1'b1;
            exit        <= 1'b1;
            state       <= REPORT;
          end else if (timeout_hit) begin
            exit_pc     <= last_pc;
            exit_inst   <= last_inst;
            exit_a0     <= 64'hFFFF_FFFF_FFFF_FFFF;
            exit_cause  <= 2'd2;
            stall_fetch <= 1'b1;
            exit        <= 1'b1;
            state       <= REPORT;
          end
        end
        DRAIN: begin
          cycle_cnt <= cycle_cnt + 64'd1;
          if (drain_cnt == DRAIN_LAST) begin
            exit  <= 1'b1;
            state <= REPORT;
          end else begin
            drain_cnt <= drain_cnt + 4'd1;
          end
        end
        REPORT:  state <= HALT;
        default: state <= HALT;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_commit_monitor.sv
// tb/tb_trap_commit_monitor.sv - scoreboard bench for trap_commit_monitor
module tb_trap_commit_monitor;
  localparam int TIMEOUT = 16;
  localparam int DRAIN   = 4;
  localparam int DEPTH   = 8;
  localparam logic [31:0] EBREAK = 32'h0010_0073;
  localparam logic [31:0] NOP    = 32'h0000_0013;
  localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] ABRT   = 64'hFFFF_FFFF_FFFF_FFFE;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        commit_valid = 1'b0;
  logic [63:0] commit_pc = '0;
  logic [31:0] commit_inst = '0;
  logic [63:0] a0 = '0;
  logic        abort_req = 1'b0;
  logic [2:0]  trace_rd_idx = '0;
  logic        stall_fetch, exit;
  logic [63:0] exit_pc, exit_a0, cycle_cnt, instret, trace_rd_pc;
  logic [31:0] exit_inst;
  logic [1:0]  exit_cause;
  logic [3:0]  trace_count;

  trap_commit_monitor #(.TIMEOUT(TIMEOUT), .DRAIN_CYCLES(DRAIN), .DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset), .commit_valid(commit_valid), .commit_pc(commit_pc),
    .commit_inst(commit_inst), .a0(a0), .abort_req(abort_req), .stall_fetch(stall_fetch),
    .exit(exit), .exit_pc(exit_pc), .exit_inst(exit_inst), .exit_a0(exit_a0),
    .exit_cause(exit_cause), .cycle_cnt(cycle_cnt), .instret(instret),
    .trace_rd_idx(trace_rd_idx), .trace_rd_pc(trace_rd_pc), .trace_count(trace_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          at;
    logic [63:0] pc;
    logic [31:0] inst;
    logic [63:0] a0v;
    logic [1:0]  cause;
    logic [63:0] ir;
    logic [63:0] cc;
  } exp_t;

  exp_t exp_q[$];
  int errors = 0, checks = 0, exits_seen = 0, exits_due = 0, rst_cyc = 0;
  logic [63:0] last_cc = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, expv);
    end
  endtask

  // Monitor: every exit strobe consumes exactly one scoreboard entry.
  always @(negedge clock) begin
    exp_t e;
    if (exit === 1'b1) begin
      exits_seen++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_exit actual=exit at cycle %0d expected=no exit", cyc);
      end else begin
        e = exp_q.pop_front();
        chk("exit_cycle", 64'(cyc), 64'(e.at));
        chk("exit_pc", exit_pc, e.pc);
        chk("exit_inst", {32'd0, exit_inst}, {32'd0, e.inst});
        chk("exit_a0", exit_a0, e.a0v);
        chk("exit_cause", {62'd0, exit_cause}, {62'd0, e.cause});
        chk("exit_instret", instret, e.ir);
        chk("exit_cycle_cnt", cycle_cnt, e.cc);
        chk("exit_stall", {63'd0, stall_fetch}, 64'd1);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    commit_valid = 1'b0;
    abort_req = 1'b0;
    step();
    step();
    rst_cyc = cyc;
    reset = 1'b0;
  endtask

  task automatic commit(input logic [63:0] pc, input logic [31:0] inst, input logic [63:0] av);
    commit_valid = 1'b1;
    commit_pc = pc;
    commit_inst = inst;
    a0 = av;
    step();
    commit_valid = 1'b0;
  endtask

  task automatic expect_exit(input int at, input logic [63:0] pc, input logic [31:0] inst,
                             input logic [63:0] av, input logic [1:0] cause, input logic [63:0] ir);
    exp_t e;
    e.at = at; e.pc = pc; e.inst = inst; e.a0v = av; e.cause = cause; e.ir = ir;
    e.cc = 64'(at - rst_cyc);
    last_cc = e.cc;
    exp_q.push_back(e);
    exits_due++;
  endtask

  task automatic wait_exits(input string name);
    int k = 0;
    while (exits_seen < exits_due && k < 200) begin
      step();
      k++;
    end
    chk(name, 64'(exits_seen), 64'(exits_due));
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_exit"}, {63'd0, exit}, 64'd0);
    chk({tag, "_stall"}, {63'd0, stall_fetch}, 64'd0);
    chk({tag, "_cause"}, {62'd0, exit_cause}, 64'd0);
    chk({tag, "_pc"}, exit_pc, 64'd0);
    chk({tag, "_inst"}, {32'd0, exit_inst}, 64'd0);
    chk({tag, "_a0"}, exit_a0, 64'd0);
    chk({tag, "_cycle_cnt"}, cycle_cnt, 64'd0);
    chk({tag, "_instret"}, instret, 64'd0);
    chk({tag, "_trace_count"}, {60'd0, trace_count}, 64'd0);
    trace_rd_idx = 3'd0;
    #1;
    chk({tag, "_trace_pc"}, trace_rd_pc, 64'd0);
  endtask

  initial begin
    // Basic ebreak with a0 = 0
    do_reset();
    check_reset_state("reset");
    commit(64'h8000_0000, NOP, 64'd0);
    commit(64'h8000_0004, NOP, 64'd0);
    commit(64'h8000_0008, EBREAK, 64'd0);
    expect_exit(cyc + DRAIN, 64'h8000_0008, EBREAK, 64'd0, 2'd1, 64'd3);
    chk("t1_stall_after_ebreak", {63'd0, stall_fetch}, 64'd1);
    wait_exits("t1_exit_seen");
    step(); step(); step();
    chk("t1_exit_low_in_halt", {63'd0, exit}, 64'd0);
    chk("t1_pc_held", exit_pc, 64'h8000_0008);
    chk("t1_cause_held", {62'd0, exit_cause}, 64'd1);
    chk("t1_cycle_frozen", cycle_cnt, last_cc);

    // Ebreak with commits and abort injected during DRAIN
    do_reset();
    commit(64'h8000_0100, EBREAK, 64'h2A);
    expect_exit(cyc + DRAIN, 64'h8000_0100, EBREAK, 64'h2A, 2'd1, 64'd1);
    commit_valid = 1'b1; commit_pc = 64'h9000_0000; commit_inst = NOP; abort_req = 1'b1;
    step(); step(); step();
    commit_valid = 1'b0; abort_req = 1'b0;
    wait_exits("t2_exit_seen");
    chk("t2_instret", instret, 64'd1);
    chk("t2_trace_count", {60'd0, trace_count}, 64'd1);
    trace_rd_idx = 3'd0;
    #1;
    chk("t2_trace_idx0", trace_rd_pc, 64'h8000_0100);

    // Timeout after a single commit
    do_reset();
    commit(64'h8000_0010, NOP, 64'd5);
    expect_exit(cyc + TIMEOUT - 1, 64'h8000_0010, NOP, ONES, 2'd2, 64'd1);
    chk("t3_stall_run", {63'd0, stall_fetch}, 64'd0);
    wait_exits("t3_exit_seen");

    // Ebreak and abort together: ebreak wins
    do_reset();
    abort_req = 1'b1;
    commit(64'h8000_0200, EBREAK, 64'd7);
    expect_exit(cyc + DRAIN, 64'h8000_0200, EBREAK, 64'd7, 2'd1, 64'd1);
    wait_exits("t4_exit_seen");
    abort_req = 1'b0;

    // Commit in the would-fire cycle suppresses the timeout and restarts idle counting
    do_reset();
    commit(64'h8000_0300, NOP, 64'd0);
    repeat (TIMEOUT - 2) step();
    commit(64'h8000_0304, NOP, 64'd0);
    chk("t5_no_stall", {63'd0, stall_fetch}, 64'd0);
    expect_exit(cyc + TIMEOUT - 1, 64'h8000_0304, NOP, ONES, 2'd2, 64'd2);
    wait_exits("t5_exit_seen");

    // External abort
    do_reset();
    commit(64'h8000_0400, NOP, 64'd0);
    step(); step();
    abort_req = 1'b1;
    step();
    abort_req = 1'b0;
    expect_exit(cyc, 64'h8000_0400, NOP, ABRT, 2'd3, 64'd1);
    wait_exits("t6_exit_seen");

    // Trace ring wrap
    do_reset();
    for (int i = 0; i < 11; i++) commit(64'(i * 4), NOP, 64'd0);
    chk("t7_trace_count", {60'd0, trace_count}, 64'd8);
    chk("t7_instret", instret, 64'd11);
    trace_rd_idx = 3'd0; #1;
    chk("t7_idx0", trace_rd_pc, 64'h28);
    trace_rd_idx = 3'd7; #1;
    chk("t7_idx7", trace_rd_pc, 64'hC);
    trace_rd_idx = 3'd3; #1;
    chk("t7_idx3", trace_rd_pc, 64'h1C);
    commit(64'h2C, EBREAK, 64'h99);
    expect_exit(cyc + DRAIN, 64'h2C, EBREAK, 64'h99, 2'd1, 64'd12);
    wait_exits("t7_exit_seen");
    step();

    // Reset while halted, then a fresh run
    do_reset();
    check_reset_state("halt_reset");
    commit(64'h8000_0500, NOP, 64'd0);
    commit(64'h8000_0504, NOP, 64'd0);
    trace_rd_idx = 3'd5; #1;
    chk("t8_idx_beyond_count", trace_rd_pc, 64'd0);
    trace_rd_idx = 3'd1; #1;
    chk("t8_idx1", trace_rd_pc, 64'h8000_0500);
    commit(64'h8000_0508, EBREAK, 64'd3);
    expect_exit(cyc + DRAIN, 64'h8000_0508, EBREAK, 64'd3, 2'd1, 64'd3);
    wait_exits("t8_exit_seen");
    step(); step();

    chk("pending_exits", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=still running expected=finished");
    $fatal(1);
  end

endmodule
